// File: rtl/rv_prefetch.sv
// Instruction prefetch unit: issues word fetches ahead of decode into a small
// {pc,inst} queue, using credit-based flow control so every response has a slot.
module rv_prefetch #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  output logic [31:0] Inst,
  output logic        isInstValid,
  input  logic        FetchStall,
  input  logic        FetchJump,
  input  logic [31:0] TargetPC,
  output logic        Address_vld,
  output logic [31:0] Address,
  input  logic        Address_rsp,
  input  logic [31:0] ReadData,
  input  logic        Data_rsp,
  output logic        WData_vld,
  output logic [31:0] WriteData
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic        rsp_ok;
  logic        issue;
  logic        push;
  logic        pop;
  logic [CW:0] credit_sum;

  // A request is only issued if its response is guaranteed a queue slot.
  assign credit_sum  = {1'b0, count_q} + {1'b0, outst_q};
  assign Address_vld = !rst && !FetchJump
                       && (outst_q < CW'(MAX_OUTST))
                       && (credit_sum < (CW + 1)'(DEPTH));
  assign Address     = fetch_pc_q;

  assign WData_vld   = 1'b0;
  assign WriteData   = 32'h0;

  assign isInstValid = !rst && (count_q != '0);
  assign PC          = pc_mem[rd_ptr_q];
  assign Inst        = inst_mem[rd_ptr_q];

  // Responses arriving with nothing outstanding are protocol errors and ignored.
  assign rsp_ok = Data_rsp && (outst_q != '0);
  assign issue  = Address_vld && Address_rsp;
  assign push   = rsp_ok && (drop_q == '0) && !FetchJump;
  assign pop    = isInstValid && !FetchStall && !FetchJump;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;

    if (FetchJump) begin
      // Everything still in flight belongs to the old stream and must be dropped.
      fetch_pc_d = TargetPC;
      resp_pc_d  = TargetPC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      outst_d    = outst_q - CW'(rsp_ok);
      drop_d     = outst_q - CW'(rsp_ok);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_ok && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      case ({issue, rsp_ok})
        2'b10:   outst_d = outst_q + CW'(1);
        2'b01:   outst_d = outst_q - CW'(1);
        default: outst_d = outst_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      inst_mem[wr_ptr_q] <= ReadData;
    end
  end

endmodule

// File: tb/tb_rv_prefetch.sv
// Directed bench for rv_prefetch: a default instance plus a DEPTH=8 instance
// starting near the top of the address space, driven by an in-order memory model.
module tb_rv_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        FetchStall;
  logic        FetchJump;
  logic [31:0] TargetPC;
  logic        Address_rsp;
  logic        Data_rsp;
  logic [31:0] ReadData;

  logic [31:0] PC, Inst, Address, WriteData;
  logic        isInstValid, Address_vld, WData_vld;
  logic [31:0] w_PC, w_Inst, w_Address, w_WriteData;
  logic        w_isInstValid, w_Address_vld, w_WData_vld;

  int checks = 0;
  int errors = 0;

  logic [31:0] pend[$];
  bit          sel_w;
  bit          mem_accept;
  bit          mem_resp;

  rv_prefetch u_dut (
    .clk(clk), .rst(rst), .PC(PC), .Inst(Inst), .isInstValid(isInstValid),
    .FetchStall(FetchStall), .FetchJump(FetchJump), .TargetPC(TargetPC),
    .Address_vld(Address_vld), .Address(Address), .Address_rsp(Address_rsp),
    .ReadData(ReadData), .Data_rsp(Data_rsp), .WData_vld(WData_vld), .WriteData(WriteData)
  );

  rv_prefetch #(.DEPTH(8), .MAX_OUTST(2), .RESET_PC(32'hFFFF_FFF8)) u_dut_w (
    .clk(clk), .rst(rst), .PC(w_PC), .Inst(w_Inst), .isInstValid(w_isInstValid),
    .FetchStall(FetchStall), .FetchJump(FetchJump), .TargetPC(TargetPC),
    .Address_vld(w_Address_vld), .Address(w_Address), .Address_rsp(Address_rsp),
    .ReadData(ReadData), .Data_rsp(Data_rsp), .WData_vld(w_WData_vld), .WriteData(w_WriteData)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hCAFE_0013;
  endfunction

  task automatic mem_drive();
    Address_rsp = mem_accept;
    if (mem_resp && pend.size() > 0) begin
      Data_rsp = 1'b1;
      ReadData = word_of(pend[0]);
    end else begin
      Data_rsp = 1'b0;
      ReadData = 32'h0;
    end
  endtask

  task automatic set_mem(input bit acc, input bit rsp);
    mem_accept = acc;
    mem_resp   = rsp;
    mem_drive();
  endtask

  // One clock cycle: record what the selected DUT issues/receives, then
  // present the next memory response after the falling edge.
  task automatic tick();
    logic        iss;
    logic [31:0] a;
    logic        rsp;
    #1;
    iss = sel_w ? (w_Address_vld && Address_rsp) : (Address_vld && Address_rsp);
    a   = sel_w ? w_Address : Address;
    rsp = Data_rsp;
    @(posedge clk);
    if (rsp && pend.size() > 0) void'(pend.pop_front());
    if (iss) pend.push_back(a);
    @(negedge clk);
    mem_drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    FetchStall = 1'b0;
    FetchJump = 1'b0;
    TargetPC = 32'h0;
    set_mem(0, 0);
    tick();
    tick();
    pend.delete();
    rst = 1'b0;
    mem_drive();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    FetchStall = 1'b0;
    FetchJump = 1'b0;
    TargetPC = 32'h0;
    set_mem(1, 1);
    tick();
    tick();
    #1;
    checks++; if (isInstValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", isInstValid); end
    checks++; if (Address_vld !== 1'b0) begin errors++; $display("FAIL reset_addr_vld: got %b want 0", Address_vld); end
    checks++; if (WData_vld !== 1'b0 || WriteData !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %b/%h want 0/0", WData_vld, WriteData); end
    pend.delete();
    rst = 1'b0;
    set_mem(0, 0);
    #1;
    checks++; if (Address !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", Address); end
    checks++; if (Address_vld !== 1'b1) begin errors++; $display("FAIL reset_first_vld: got %b want 1", Address_vld); end
    checks++; if (isInstValid !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b want 0", isInstValid); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    set_mem(1, 1);
    exp_pc = 32'h0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c >= 2) begin
        checks++; if (isInstValid !== 1'b1) begin errors++; $display("FAIL stream_valid c%0d: got %b want 1", c, isInstValid); end
        checks++; if (PC !== exp_pc) begin errors++; $display("FAIL stream_pc c%0d: got %h want %h", c, PC, exp_pc); end
        checks++; if (Inst !== word_of(exp_pc)) begin errors++; $display("FAIL stream_inst c%0d: got %h want %h", c, Inst, word_of(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end else begin
        checks++; if (isInstValid !== 1'b0) begin errors++; $display("FAIL stream_warmup c%0d: got %b want 0", c, isInstValid); end
      end
      tick();
    end
    $display("test_stream done");
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    do_reset();
    FetchStall = 1'b1;
    set_mem(1, 1);
    repeat (10) tick();
    FetchStall = 1'b0;
    #1;
    checks++; if (Address_vld !== 1'b0) begin errors++; $display("FAIL stall_full_vld: got %b want 0", Address_vld); end
    checks++; if (Address !== 32'h10) begin errors++; $display("FAIL stall_fetch_pc: got %h want 00000010", Address); end
    exp_pc = 32'h0;
    for (int r = 0; r < 5; r++) begin
      checks++; if (isInstValid !== 1'b1 || PC !== exp_pc) begin errors++; $display("FAIL stall_pop r%0d: got %b/%h want 1/%h", r, isInstValid, PC, exp_pc); end
      if (r == 0) begin
        checks++; if (Address_vld !== 1'b0) begin errors++; $display("FAIL stall_release_vld: got %b want 0", Address_vld); end
      end
      if (r == 1) begin
        checks++; if (Address_vld !== 1'b1 || Address !== 32'h10) begin errors++; $display("FAIL stall_resume: got %b/%h want 1/00000010", Address_vld, Address); end
      end
      exp_pc = exp_pc + 32'd4;
      tick();
      #1;
    end
    $display("test_stall done");
  endtask

  task automatic test_jump();
    do_reset();
    set_mem(1, 1);
    tick();
    tick();
    tick();
    set_mem(1, 0);
    tick();
    #1;
    checks++; if (Address_vld !== 1'b0 || isInstValid !== 1'b0) begin errors++; $display("FAIL jump_setup: got vld=%b valid=%b want 0/0", Address_vld, isInstValid); end
    FetchJump = 1'b1;
    TargetPC = 32'h100;
    tick();
    FetchJump = 1'b0;
    set_mem(1, 1);
    #1;
    checks++; if (isInstValid !== 1'b0) begin errors++; $display("FAIL jump_flush: got %b want 0", isInstValid); end
    checks++; if (Address !== 32'h100) begin errors++; $display("FAIL jump_target: got %h want 00000100", Address); end
    tick();
    #1;
    checks++; if (isInstValid !== 1'b0) begin errors++; $display("FAIL jump_drop1: got %b want 0", isInstValid); end
    checks++; if (Address_vld !== 1'b1 || Address !== 32'h100) begin errors++; $display("FAIL jump_issue: got %b/%h want 1/00000100", Address_vld, Address); end
    tick();
    #1;
    checks++; if (isInstValid !== 1'b0) begin errors++; $display("FAIL jump_drop2: got %b want 0", isInstValid); end
    tick();
    #1;
    checks++; if (isInstValid !== 1'b1 || PC !== 32'h100) begin errors++; $display("FAIL jump_first_pc: got %b/%h want 1/00000100", isInstValid, PC); end
    checks++; if (Inst !== word_of(32'h100)) begin errors++; $display("FAIL jump_first_inst: got %h want %h", Inst, word_of(32'h100)); end
    $display("test_jump done");
  endtask

  task automatic test_jump_with_rsp();
    do_reset();
    set_mem(1, 1);
    repeat (5) tick();
    #1;
    checks++; if (isInstValid !== 1'b1 || PC !== 32'hC) begin errors++; $display("FAIL jrsp_pre: got %b/%h want 1/0000000c", isInstValid, PC); end
    FetchJump = 1'b1;
    TargetPC = 32'h200;
    tick();
    FetchJump = 1'b0;
    #1;
    checks++; if (isInstValid !== 1'b0) begin errors++; $display("FAIL jrsp_flush: got %b want 0", isInstValid); end
    checks++; if (Address_vld !== 1'b1 || Address !== 32'h200) begin errors++; $display("FAIL jrsp_issue: got %b/%h want 1/00000200", Address_vld, Address); end
    tick();
    tick();
    #1;
    checks++; if (isInstValid !== 1'b1 || PC !== 32'h200) begin errors++; $display("FAIL jrsp_first_pc: got %b/%h want 1/00000200", isInstValid, PC); end
    checks++; if (Inst !== word_of(32'h200)) begin errors++; $display("FAIL jrsp_first_inst: got %h want %h", Inst, word_of(32'h200)); end
    $display("test_jump_with_rsp done");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    do_reset();
    sel_w = 1'b1;
    FetchStall = 1'b1;
    set_mem(1, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (w_Address_vld !== 1'b1 || w_Address !== exp_addr[c]) begin errors++; $display("FAIL wrap_addr c%0d: got %b/%h want 1/%h", c, w_Address_vld, w_Address, exp_addr[c]); end
      tick();
    end
    tick();
    FetchStall = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (w_isInstValid !== 1'b1 || w_PC !== exp_addr[c]) begin errors++; $display("FAIL wrap_head c%0d: got %b/%h want 1/%h", c, w_isInstValid, w_PC, exp_addr[c]); end
      checks++; if (w_Inst !== word_of(exp_addr[c])) begin errors++; $display("FAIL wrap_inst c%0d: got %h want %h", c, w_Inst, word_of(exp_addr[c])); end
      tick();
    end
    sel_w = 1'b0;
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    sel_w = 1'b1;
    FetchStall = 1'b1;
    set_mem(1, 1);
    repeat (4) tick();
    set_mem(1, 0);
    tick();
    #1;
    checks++; if (w_isInstValid !== 1'b1 || w_Address_vld !== 1'b0) begin errors++; $display("FAIL mid_setup: got valid=%b vld=%b want 1/0", w_isInstValid, w_Address_vld); end
    rst = 1'b1;
    set_mem(0, 0);
    #1;
    checks++; if (w_isInstValid !== 1'b0 || w_Address_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_hold: got valid=%b vld=%b want 0/0", w_isInstValid, w_Address_vld); end
    tick();
    rst = 1'b0;
    set_mem(0, 1);
    #1;
    checks++; if (w_Address !== 32'hFFFF_FFF8 || w_isInstValid !== 1'b0) begin errors++; $display("FAIL mid_post_rst: got %h/%b want fffffff8/0", w_Address, w_isInstValid); end
    tick();
    #1;
    checks++; if (w_isInstValid !== 1'b0) begin errors++; $display("FAIL mid_stray1: got %b want 0", w_isInstValid); end
    tick();
    set_mem(1, 1);
    #1;
    checks++; if (w_isInstValid !== 1'b0) begin errors++; $display("FAIL mid_stray2: got %b want 0", w_isInstValid); end
    checks++; if (w_Address_vld !== 1'b1 || w_Address !== 32'hFFFF_FFF8) begin errors++; $display("FAIL mid_first_fetch: got %b/%h want 1/fffffff8", w_Address_vld, w_Address); end
    tick();
    tick();
    #1;
    checks++; if (w_isInstValid !== 1'b1 || w_PC !== 32'hFFFF_FFF8 || w_Inst !== word_of(32'hFFFF_FFF8)) begin errors++; $display("FAIL mid_first_head: got %b/%h/%h want 1/fffffff8/%h", w_isInstValid, w_PC, w_Inst, word_of(32'hFFFF_FFF8)); end
    checks++; if (w_WData_vld !== 1'b0) begin errors++; $display("FAIL mid_wdata: got %b want 0", w_WData_vld); end
    sel_w = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1;
    FetchStall = 1'b0;
    FetchJump = 1'b0;
    TargetPC = 32'h0;
    sel_w = 1'b0;
    set_mem(0, 0);
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_jump_with_rsp();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_prefetch.md
RV_PREFETCH -- requirements
Module: rv_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries (power of 2, >=2).
REQ-002 SHALL have parameter MAX_OUTST, default 2, maximum accepted-but-unanswered memory requests (1..DEPTH).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port PC  output  32  PC of queue head instruction.
REQ-007 SHALL have port Inst  output  32  queue head instruction word (RV32InstType).
REQ-008 SHALL have port isInstValid  output  1  queue non-empty, head valid.
REQ-009 SHALL have port FetchStall  input  1  decode not consuming this cycle.
REQ-010 SHALL have port FetchJump  input  1  redirect request.
REQ-011 SHALL have port TargetPC  input  32  redirect address.
REQ-012 SHALL have port Address_vld  output  1  memory request valid.
REQ-013 SHALL have port Address  output  32  request address (word aligned).
REQ-014 SHALL have port Address_rsp  input  1  request accepted this cycle.
REQ-015 SHALL have port ReadData  input  32  returned instruction word.
REQ-016 SHALL have port Data_rsp  input  1  ReadData valid, responses in request order.
REQ-017 SHALL have ports WData_vld, WriteData  output  1/32  tied to 0.

Function
REQ-018 SHALL keep registers: fetch_pc, resp_pc, queue of DEPTH {pc,inst} entries with rd/wr pointers and count, outst counter, drop counter.
REQ-019 SHALL drive Address=fetch_pc and Address_vld = !rst & !FetchJump & (outst<MAX_OUTST) & (count+outst<DEPTH).
REQ-020 SHALL, on Address_vld & Address_rsp, increment outst and advance fetch_pc by 4 (mod 2^32 wrap).
REQ-021 SHALL, on Data_rsp with drop==0, write {resp_pc,ReadData} at wr pointer, increment resp_pc by 4, decrement outst.
REQ-022 SHALL, on Data_rsp with drop>0, discard data, decrement drop and outst; queue and resp_pc unchanged.
REQ-023 SHALL expose head entry combinationally from registers; isInstValid = count!=0; data written at edge N visible at N+1 (1-cycle latency).
REQ-024 SHALL pop head on isInstValid & !FetchStall & !FetchJump.
REQ-025 SHALL support simultaneous push and pop (count unchanged), and simultaneous request accept and response (outst unchanged).
REQ-026 SHALL never overflow: credit rule in REQ-019 guarantees free slot for every outstanding response.
REQ-027 SHALL, on FetchJump, flush queue (count=0, pointers reset), set fetch_pc=resp_pc=TargetPC, set drop = outst minus 1 if Data_rsp that cycle else outst; Data_rsp that cycle discarded.
REQ-028 SHALL give FetchJump priority over pop, push and issue in the same cycle.
REQ-029 SHALL resume issuing from TargetPC the cycle after FetchJump, even with drop>0.
REQ-030 SHALL ignore Data_rsp when outst==0 (protocol error, no state change).
REQ-031 SHALL wrap queue pointers modulo DEPTH.

Reset
REQ-032 SHALL on rst set fetch_pc=resp_pc=RESET_PC, count=outst=drop=0, pointers=0.
REQ-033 SHALL hold isInstValid=0 and Address_vld=0 while rst high; Address=RESET_PC the cycle after rst deasserts.
REQ-034 SHALL abandon in-flight requests on rst mid-operation; post-reset responses without matching request fall under REQ-030.

Verification
REQ-035 Zero-wait memory (Address_rsp=1, Data_rsp 1 cycle later), FetchStall=0 -> PC 0x0,0x4,0x8... one instruction per cycle after warm-up.
REQ-036 FetchStall=1 held, DEPTH=4 -> exactly 4 words queued, Address_vld=0 with count+outst=4; release -> 4 pops in order, fetch resumes at 0x10.
REQ-037 Two outstanding (addr 0x8,0xC), FetchJump TargetPC=0x100 -> queue empty next cycle, both responses discarded, first valid PC=0x100.
REQ-038 FetchJump same cycle as Data_rsp and pop -> response dropped, no pop, drop=outst-1.
REQ-039 RESET_PC=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0 with matching head PC.
REQ-040 rst asserted with 2 outstanding and 3 queued -> isInstValid=0, Address_vld=0; stray Data_rsp after release ignored, first fetch at RESET_PC.
